code_decoder_seq: RTL and testbench

Sequenced 3-to-8 decoder: the receive-side counterpart of the 8-to-3 priority encoder. It accepts 3-bit codes over a valid/ready handshake and buffers them in a small FIFO. Each code is replayed, in arrival order, as a registered one-hot 8-bit pattern held for a programmable number of cycles, with an optional idle gap between patterns. It sits where encoded request indices must be turned back into per-line strobes, for example LED or channel select lines.

---
 rtl/code_decoder_seq.sv | 146 ++++++++++++++
 tb/tb_code_decoder_seq.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/code_decoder_seq.sv
// Sequenced 3-to-8 decoder: buffers 3-bit codes in a FIFO and replays each one as a
// registered one-hot pattern held for HOLD cycles, followed by GAP idle cycles.
module code_decoder_seq #(
  parameter int HOLD  = 4,
  parameter int GAP   = 1,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         clr,
  input  logic [2:0]                   in,
  input  logic                         in_valid,
  output logic                         in_ready,
  output logic [7:0]                   out,
  output logic                         out_valid,
  output logic [$clog2(DEPTH+1)-1:0]   level,
  output logic [1:0]                   dbg_state
);

  localparam int AW   = $clog2(DEPTH);
  localparam int LW   = $clog2(DEPTH+1);
  localparam int CMAX = (HOLD > GAP) ? HOLD : GAP;
  localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, DRIVE = 2'd1, SPACE = 2'd2} state_t;

  // Handshake: a code transfers on a rising edge where in_valid && in_ready && !clr.
  // in_ready depends on the stored count only, so a same-cycle pop never frees a slot.

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [LW-1:0] r_count;
  logic [7:0]    r_out;
  logic          r_out_valid;

  logic          w_push;
  logic          w_pop;
  logic          w_has;
  logic [7:0]    w_head_oh;

  assign w_has     = (r_count != '0);
  assign in_ready  = (r_count < LW'(DEPTH));
  assign w_push    = in_valid && in_ready && !clr;
  assign w_head_oh = 8'd1 << r_mem[r_rptr];

  assign out       = r_out;
  assign out_valid = r_out_valid;
  assign level     = r_count;
  assign dbg_state = r_state;

  always_comb begin
    w_pop = 1'b0;
    case (r_state)
      IDLE:    w_pop = w_has;
      DRIVE:   w_pop = (r_cnt == '0) && (GAP == 0) && w_has;
      SPACE:   w_pop = (r_cnt == '0) && w_has;
      default: w_pop = 1'b0;
    endcase
    if (clr) w_pop = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (clr) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + LW'(1);
        2'b01:   r_count <= r_count - LW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_out       <= 8'h00;
      r_out_valid <= 1'b0;
    end else if (clr) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_out       <= 8'h00;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_pop) begin
            r_out       <= w_head_oh;
            r_out_valid <= 1'b1;
            r_cnt       <= CW'(HOLD-1);
            r_state     <= DRIVE;
          end
        end
        DRIVE: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - CW'(1);
          end else if (GAP > 0) begin
            r_out       <= 8'h00;
            r_out_valid <= 1'b0;
            r_cnt       <= CW'(GAP-1);
            r_state     <= SPACE;
          end else if (w_pop) begin
            // Back-to-back reload keeps out_valid high with no zero cycle.
            r_out       <= w_head_oh;
            r_out_valid <= 1'b1;
            r_cnt       <= CW'(HOLD-1);
          end else begin
            r_out       <= 8'h00;
            r_out_valid <= 1'b0;
            r_state     <= IDLE;
          end
        end
        SPACE: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - CW'(1);
          end else if (w_pop) begin
            r_out       <= w_head_oh;
            r_out_valid <= 1'b1;
            r_cnt       <= CW'(HOLD-1);
            r_state     <= DRIVE;
          end else begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_code_decoder_seq.sv
// Bench for code_decoder_seq: instance A (HOLD=1, GAP=0) for the mapping sweep,
// instance B (HOLD=4, GAP=1) for timing, backpressure, flush and reset.
module tb_code_decoder_seq;

  localparam int HA = 1;
  localparam int HB = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       a_clr = 1'b0, b_clr = 1'b0;
  logic [2:0] a_in = '0, b_in = '0;
  logic       a_in_valid = 1'b0, b_in_valid = 1'b0;
  logic       a_in_ready, b_in_ready;
  logic [7:0] a_out, b_out;
  logic       a_out_valid, b_out_valid;
  logic [2:0] a_level, b_level;
  logic [1:0] a_state, b_state;

  code_decoder_seq #(.HOLD(HA), .GAP(0), .DEPTH(4)) u_a (
    .clk(clk), .rst_n(rst_n), .clr(a_clr), .in(a_in), .in_valid(a_in_valid),
    .in_ready(a_in_ready), .out(a_out), .out_valid(a_out_valid), .level(a_level),
    .dbg_state(a_state));

  code_decoder_seq #(.HOLD(HB), .GAP(1), .DEPTH(4)) u_b (
    .clk(clk), .rst_n(rst_n), .clr(b_clr), .in(b_in), .in_valid(b_in_valid),
    .in_ready(b_in_ready), .out(b_out), .out_valid(b_out_valid), .level(b_level),
    .dbg_state(b_state));

  int n_checks = 0;
  int n_err = 0;
  logic [7:0] exp_a[$];
  logic [7:0] exp_b[$];

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [7:0] oh(input logic [2:0] c);
    logic [7:0] one;
    one = 8'd1;
    return one << c;
  endfunction

  // Scoreboard monitors: a new pattern starts on a rising out_valid or after HOLD cycles.
  int a_run = 0, a_vrun = 0, a_vmax = 0;
  logic [7:0] a_cur = '0;
  always @(negedge clk) begin
    if (!rst_n) begin
      a_run = 0; a_vrun = 0;
    end else if (a_out_valid) begin
      a_vrun++;
      if (a_vrun > a_vmax) a_vmax = a_vrun;
      if (a_run == 0 || a_run == HA) begin
        if (exp_a.size() == 0) chk("a_extra", a_out, 8'h00);
        else chk("a_order", a_out, exp_a.pop_front());
        a_run = 1; a_cur = a_out;
      end else begin
        chk("a_hold", a_out, a_cur); a_run++;
      end
    end else begin
      a_vrun = 0;
      chk("a_zero", a_out, 8'h00);
      if (a_run != 0) chk("a_holdlen", a_run, HA);
      a_run = 0;
    end
  end

  int b_run = 0;
  logic b_abort = 1'b0;
  logic [7:0] b_cur = '0;
  always @(negedge clk) begin
    if (!rst_n || b_abort) begin
      b_run = 0; b_abort = 1'b0;
    end else if (b_out_valid) begin
      if (b_run == 0 || b_run == HB) begin
        if (exp_b.size() == 0) chk("b_extra", b_out, 8'h00);
        else chk("b_order", b_out, exp_b.pop_front());
        b_run = 1; b_cur = b_out;
      end else begin
        chk("b_hold", b_out, b_cur); b_run++;
      end
    end else begin
      chk("b_zero", b_out, 8'h00);
      if (b_run != 0) chk("b_holdlen", b_run, HB);
      b_run = 0;
    end
  end

  task automatic push_a(input logic [2:0] c);
    int k = 0;
    a_in = c; a_in_valid = 1'b1;
    while (!a_in_ready && k < 200) begin @(posedge clk); #1; k++; end
    chk("a_push_ready", a_in_ready, 1);
    @(posedge clk);
    exp_a.push_back(oh(c));
    #1 a_in_valid = 1'b0;
  endtask

  task automatic push_b(input logic [2:0] c);
    int k = 0;
    b_in = c; b_in_valid = 1'b1;
    while (!b_in_ready && k < 200) begin @(posedge clk); #1; k++; end
    chk("b_push_ready", b_in_ready, 1);
    @(posedge clk);
    exp_b.push_back(oh(c));
    #1 b_in_valid = 1'b0;
  endtask

  task automatic drain_b();
    int k = 0;
    while ((exp_b.size() != 0 || b_out_valid) && k < 300) begin @(posedge clk); #1; k++; end
    repeat (3) @(posedge clk);
    #1;
    chk("b_drain_q", exp_b.size(), 0);
    chk("b_drain_level", b_level, 0);
  endtask

  logic [7:0] hg_out [12] = '{8'h00, 8'h20, 8'h20, 8'h20, 8'h20, 8'h00,
                              8'h04, 8'h04, 8'h04, 8'h04, 8'h00, 8'h08};

  initial begin
    int nz;
    // Reset state, with a push attempt that must be ignored.
    b_in = 3'd3; b_in_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready_b", b_in_ready, 1);
    chk("rst_ready_a", a_in_ready, 1);
    chk("rst_out_b", b_out, 8'h00);
    chk("rst_valid_b", b_out_valid, 0);
    chk("rst_level_b", b_level, 0);
    chk("rst_level_a", a_level, 0);
    b_in_valid = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Mapping sweep on A: 8 contiguous one-hot patterns.
    a_vmax = 0;
    for (int i = 0; i < 8; i++) push_a(i[2:0]);
    repeat (4) @(posedge clk);
    #1;
    chk("a_contig_len", a_vmax, 8);
    chk("a_sweep_q", exp_a.size(), 0);

    // Hold/gap timing on B, with a simultaneous push/pop at level 2 on edge 6.
    for (int e = 0; e < 12; e++) begin
      case (e)
        0: begin b_in = 3'd5; b_in_valid = 1'b1; end
        1: begin b_in = 3'd2; b_in_valid = 1'b1; end
        2: begin b_in = 3'd3; b_in_valid = 1'b1; end
        6: begin b_in = 3'd6; b_in_valid = 1'b1; end
        default: b_in_valid = 1'b0;
      endcase
      @(posedge clk);
      if (b_in_valid) exp_b.push_back(oh(b_in));
      #1 b_in_valid = 1'b0;
      chk("hg_out", b_out, hg_out[e]);
      if (e == 2 || e == 6) chk("hg_level", b_level, 2);
    end
    drain_b();

    // Backpressure: codes 1..6 with the FIFO filling to DEPTH.
    for (int i = 1; i <= 5; i++) push_b(i[2:0]);
    chk("bp_level", b_level, 4);
    chk("bp_ready", b_in_ready, 0);
    push_b(3'd6);
    drain_b();

    // Flush during the second DRIVE cycle of code 3, two queued, push in same cycle.
    push_b(3'd3);
    push_b(3'd4);
    push_b(3'd5);
    chk("fl_pre_out", b_out, 8'h08);
    chk("fl_pre_level", b_level, 2);
    b_clr = 1'b1; b_in = 3'd7; b_in_valid = 1'b1;
    @(posedge clk);
    #1 b_clr = 1'b0; b_in_valid = 1'b0;
    exp_b.delete();
    b_abort = 1'b1;
    chk("fl_out", b_out, 8'h00);
    chk("fl_valid", b_out_valid, 0);
    chk("fl_level", b_level, 0);
    nz = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (b_out_valid || b_out != 8'h00 || b_level != 3'd0) nz++;
    end
    chk("fl_quiet", nz, 0);

    // Asynchronous reset while out = 8'h80.
    push_b(3'd7);
    @(posedge clk); #1;
    chk("ar_pre_out", b_out, 8'h80);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_out", b_out, 8'h00);
    chk("ar_valid", b_out_valid, 0);
    chk("ar_level", b_level, 0);
    exp_b.delete();
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    b_in = 3'd0; b_in_valid = 1'b1;
    @(posedge clk);
    exp_b.push_back(oh(3'd0));
    #1 b_in_valid = 1'b0;
    chk("ar_lat0", b_out, 8'h00);
    @(posedge clk); #1;
    chk("ar_lat1", b_out, 8'h01);
    drain_b();

    chk("end_q_a", exp_a.size(), 0);
    chk("end_q_b", exp_b.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
